// File: rtl/cdc_hs_arbiter.sv
// Round-robin arbiter that funnels NumReq requesters into one handshake CDC source channel,
// holding each granted transfer until hs_ready_i and inserting one idle GAP cycle afterwards.
module cdc_hs_arbiter #(
    parameter int  NumReq        = 4,
    parameter int  DataWidth     = 32,
    parameter int  TimeoutCycles = 1023,
    localparam int IdWidth       = $clog2(NumReq)
) (
    input  logic                          src_clk,
    input  logic                          reset,
    input  logic [NumReq-1:0]             req_valid_i,
    input  logic [NumReq*DataWidth-1:0]   req_data_i,
    output logic [NumReq-1:0]             req_ready_o,
    output logic [IdWidth+DataWidth-1:0]  hs_data_o,
    output logic                          hs_valid_o,
    input  logic                          hs_ready_i,
    output logic [IdWidth-1:0]            grant_id_o,
    output logic                          busy_o,
    output logic                          timeout_o
);

    localparam int IdxWidth = IdWidth + 1;
    localparam int WdWidth  = $clog2(TimeoutCycles + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } state_e;

    state_e                 state_q, state_d;
    logic [IdWidth-1:0]     last_grant_q, last_grant_d;
    logic [WdWidth-1:0]     wd_q, wd_d;
    logic [IdWidth-1:0]     hold_id_q, hold_id_d;
    logic [DataWidth-1:0]   hold_data_q, hold_data_d;
    logic                   hs_valid_q, hs_valid_d;
    logic                   busy_q, busy_d;
    logic                   timeout_q, timeout_d;

    logic                   grant_found;
    logic [IdWidth-1:0]     grant_idx;
    logic [IdxWidth-1:0]    cand;
    logic                   grant_en;

    // Round-robin search starting one past the last winner; cand never exceeds 2*NumReq-1,
    // so a single conditional subtract implements the wrap.
    // NOTE: every variable assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NumReq; i++) begin
            cand = {1'b0, last_grant_q} + IdxWidth'(1) + IdxWidth'(i);
            if (cand >= IdxWidth'(NumReq)) begin
                cand = cand - IdxWidth'(NumReq);
            end
            if (!grant_found && req_valid_i[cand[IdWidth-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IdWidth-1:0];
            end
        end
    end

    assign grant_en = (state_q == ST_IDLE) && grant_found && !reset;

    always_comb begin
        req_ready_o = '0;
        if (grant_en) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        wd_d         = wd_q;
        hold_id_d    = hold_id_q;
        hold_data_d  = hold_data_q;
        timeout_d    = timeout_q;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    state_d      = ST_SEND;
                    last_grant_d = grant_idx;
                    hold_id_d    = grant_idx;
                    hold_data_d  = req_data_i[int'(grant_idx)*DataWidth +: DataWidth];
                    wd_d         = '0;
                end
            end
            ST_SEND: begin
                if (hs_ready_i) begin
                    state_d = ST_GAP;
                end else if (wd_q != WdWidth'(TimeoutCycles)) begin
                    wd_d = wd_q + WdWidth'(1);
                end
                // The cycle in which the count reaches the limit raises the flag even when
                // hs_ready_i completes the transfer in that same cycle.
                if (wd_q >= WdWidth'(TimeoutCycles - 1)) begin
                    timeout_d = 1'b1;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        hs_valid_d = (state_d == ST_SEND);
        busy_d     = (state_d != ST_IDLE);
    end

    // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge src_clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IdWidth'(NumReq - 1);
            wd_q         <= '0;
            // NOTE: the hold register is a plain register, not a memory, and is reset so hs_data_o is defined from the first cycle.
            hold_id_q    <= '0;
            hold_data_q  <= '0;
            hs_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wd_q         <= wd_d;
            hold_id_q    <= hold_id_d;
            hold_data_q  <= hold_data_d;
            hs_valid_q   <= hs_valid_d;
            busy_q       <= busy_d;
            timeout_q    <= timeout_d;
        end
    end

    assign hs_data_o  = {hold_id_q, hold_data_q};
    assign hs_valid_o = hs_valid_q;
    assign grant_id_o = hold_id_q;
    assign busy_o     = busy_q;
    assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_cdc_hs_arbiter.sv
// Directed bench for cdc_hs_arbiter: inputs change on the falling edge, outputs are
// compared 1 time unit later with immediate assertions.
module tb_cdc_hs_arbiter;

    localparam int NumReq    = 4;
    localparam int DataWidth = 32;
    localparam int IdWidth   = 2;

    logic                          clk;
    logic                          reset;
    logic [NumReq-1:0]             req_valid;
    logic [NumReq*DataWidth-1:0]   req_data;
    logic [NumReq-1:0]             req_ready;
    logic [IdWidth+DataWidth-1:0]  hs_data;
    logic                          hs_valid;
    logic                          hs_ready;
    logic [IdWidth-1:0]            grant_id;
    logic                          busy;
    logic                          timeout;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DataWidth-1:0] exp_data [NumReq] = '{32'h0BAD_F00D, 32'h5A5A_0001, 32'hA5A5_A5A5, 32'hDDDD_0003};
    int rr_ids [5] = '{0, 1, 2, 3, 0};

    cdc_hs_arbiter #(
        .NumReq        (NumReq),
        .DataWidth     (DataWidth),
        .TimeoutCycles (8)
    ) dut (
        .src_clk     (clk),
        .reset       (reset),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .hs_data_o   (hs_data),
        .hs_valid_o  (hs_valid),
        .hs_ready_i  (hs_ready),
        .grant_id_o  (grant_id),
        .busy_o      (busy),
        .timeout_o   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic drive(input logic [NumReq-1:0] v, input logic rdy, input logic rst);
        req_valid = v;
        hs_ready  = rdy;
        reset     = rst;
        #1;
    endtask

    function automatic logic [63:0] exp_hs(input int id);
        logic [IdWidth+DataWidth-1:0] w;
        w = {IdWidth'(id), exp_data[id]};
        return 64'(w);
    endfunction

    function automatic logic [63:0] onehot(input int id);
        return 64'(1) << id;
    endfunction

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        hs_ready  = 1'b0;
        req_data  = {exp_data[3], exp_data[2], exp_data[1], exp_data[0]};

        // Reset state; ready stays low under reset even with every requester valid
        cyc(); drive(4'b1111, 1'b0, 1'b1);
        check("rst_ready",   64'(req_ready), 64'(0));
        check("rst_valid",   64'(hs_valid),  64'(0));
        check("rst_busy",    64'(busy),      64'(0));
        check("rst_timeout", 64'(timeout),   64'(0));
        check("rst_gid",     64'(grant_id),  64'(0));
        check("rst_data",    64'(hs_data),   64'(0));

        cyc(); drive(4'b0000, 1'b0, 1'b0);
        check("idle_ready", 64'(req_ready), 64'(0));

        // Single request from requester 2
        cyc(); drive(4'b0100, 1'b0, 1'b0);
        check("single_ready", 64'(req_ready), 64'(4'b0100));
        check("single_pre_valid", 64'(hs_valid), 64'(0));
        cyc(); drive(4'b0000, 1'b0, 1'b0);
        check("single_valid", 64'(hs_valid), 64'(1));
        check("single_data",  64'(hs_data),  exp_hs(2));
        check("single_gid",   64'(grant_id), 64'(2));
        check("single_busy",  64'(busy),     64'(1));
        check("single_send_ready", 64'(req_ready), 64'(0));
        cyc(); drive(4'b0000, 1'b0, 1'b0);
        check("single_hold", 64'(hs_valid), 64'(1));
        cyc(); drive(4'b0000, 1'b1, 1'b0);
        check("single_ack_cycle", 64'(hs_valid), 64'(1));
        cyc(); drive(4'b0000, 1'b0, 1'b0);
        check("single_gap_valid", 64'(hs_valid), 64'(0));
        check("single_gap_busy",  64'(busy),     64'(1));

        // Spurious ready in IDLE with no requests
        cyc(); drive(4'b0000, 1'b1, 1'b0);
        check("spur_busy",  64'(busy),      64'(0));
        check("spur_ready", 64'(req_ready), 64'(0));
        check("spur_data_held", 64'(hs_data), exp_hs(2));
        cyc(); drive(4'b0000, 1'b0, 1'b0);
        check("spur_after_busy",  64'(busy),     64'(0));
        check("spur_after_valid", 64'(hs_valid), 64'(0));

        // Round robin with all four requesters held valid
        cyc(); drive(4'b1111, 1'b0, 1'b1);
        cyc(); drive(4'b1111, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("rr%0d_grant", k), 64'(req_ready), onehot(rr_ids[k]));
            check($sformatf("rr%0d_idle_valid", k), 64'(hs_valid), 64'(0));
            cyc(); drive(4'b1111, 1'b0, 1'b0);
            check($sformatf("rr%0d_valid", k), 64'(hs_valid), 64'(1));
            check($sformatf("rr%0d_gid", k),   64'(grant_id), 64'(rr_ids[k]));
            check($sformatf("rr%0d_data", k),  64'(hs_data),  exp_hs(rr_ids[k]));
            cyc(); drive(4'b1111, 1'b0, 1'b0);
            check($sformatf("rr%0d_hold", k), 64'(hs_valid), 64'(1));
            cyc(); drive(4'b1111, 1'b1, 1'b0);
            check($sformatf("rr%0d_ack", k), 64'(hs_valid), 64'(1));
            cyc(); drive(4'b1111, 1'b0, 1'b0);
            check($sformatf("rr%0d_gap_valid", k), 64'(hs_valid),  64'(0));
            check($sformatf("rr%0d_gap_ready", k), 64'(req_ready), 64'(0));
            cyc(); drive(4'b1111, 1'b0, 1'b0);
        end

        // Minimum gap: only requester 1 valid, two cycles after the last ack
        drive(4'b0010, 1'b0, 1'b0);
        check("gap_s2_ready", 64'(req_ready), 64'(4'b0010));
        check("gap_s2_valid", 64'(hs_valid),  64'(0));

        // Watchdog with hs_ready held low
        for (int k = 1; k <= 8; k++) begin
            cyc(); drive(4'b0000, 1'b0, 1'b0);
            check($sformatf("wd_send%0d_valid", k), 64'(hs_valid), 64'(1));
            check($sformatf("wd_send%0d_to", k),    64'(timeout),  64'(0));
        end
        check("wd_gid", 64'(grant_id), 64'(1));
        cyc(); drive(4'b0000, 1'b0, 1'b0);
        check("wd_to_set",   64'(timeout),  64'(1));
        check("wd_to_valid", 64'(hs_valid), 64'(1));
        cyc(); drive(4'b0000, 1'b1, 1'b0);
        check("wd_late_ack", 64'(hs_valid), 64'(1));
        cyc(); drive(4'b0000, 1'b0, 1'b0);
        check("wd_gap_valid", 64'(hs_valid), 64'(0));
        check("wd_gap_to",    64'(timeout),  64'(1));
        cyc(); drive(4'b0000, 1'b0, 1'b0);
        check("wd_idle_busy", 64'(busy),    64'(0));
        check("wd_idle_to",   64'(timeout), 64'(1));

        // Ack in the very cycle the watchdog reaches its limit
        cyc(); drive(4'b0000, 1'b0, 1'b1);
        cyc(); drive(4'b1000, 1'b0, 1'b0);
        check("edge_to_cleared", 64'(timeout),   64'(0));
        check("edge_grant",      64'(req_ready), 64'(4'b1000));
        for (int k = 1; k <= 7; k++) begin
            cyc(); drive(4'b0000, 1'b0, 1'b0);
            check($sformatf("edge_send%0d_to", k), 64'(timeout), 64'(0));
        end
        cyc(); drive(4'b0000, 1'b1, 1'b0);
        check("edge_send8_valid", 64'(hs_valid), 64'(1));
        check("edge_send8_to",    64'(timeout),  64'(0));
        cyc(); drive(4'b0000, 1'b0, 1'b0);
        check("edge_done_valid", 64'(hs_valid), 64'(0));
        check("edge_done_to",    64'(timeout),  64'(1));
        check("edge_done_busy",  64'(busy),     64'(1));

        // Reset in the third SEND cycle discards the transfer
        cyc(); drive(4'b0000, 1'b0, 1'b1);
        cyc(); drive(4'b0100, 1'b0, 1'b0);
        check("mid_grant",   64'(req_ready), 64'(4'b0100));
        check("mid_to_clr",  64'(timeout),   64'(0));
        cyc(); drive(4'b0000, 1'b0, 1'b0);
        check("mid_send1_gid", 64'(grant_id), 64'(2));
        cyc(); drive(4'b0000, 1'b0, 1'b0);
        cyc(); drive(4'b0101, 1'b0, 1'b1);
        check("mid_send3_valid", 64'(hs_valid),  64'(1));
        check("mid_rst_ready",   64'(req_ready), 64'(0));
        cyc(); drive(4'b0101, 1'b0, 1'b0);
        check("mid_after_valid", 64'(hs_valid),  64'(0));
        check("mid_after_busy",  64'(busy),      64'(0));
        check("mid_after_gid",   64'(grant_id),  64'(0));
        check("mid_after_data",  64'(hs_data),   64'(0));
        check("mid_regrant",     64'(req_ready), 64'(4'b0001));
        cyc(); drive(4'b0000, 1'b0, 1'b0);
        check("mid_next_valid", 64'(hs_valid), 64'(1));
        check("mid_next_data",  64'(hs_data),  exp_hs(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
